// File: rtl/bids22_pkg.sv
// Shared types for the bids22 auction controller and its host command sequencer.
package bids22_pkg;

    typedef enum logic [3:0] {
        NoOp       = 4'd0,
        Unlock     = 4'd1,
        Lock       = 4'd2,
        LoadX      = 4'd3,
        LoadY      = 4'd4,
        LoadZ      = 4'd5,
        SetXYZmask = 4'd6,
        SetTimer   = 4'd7,
        BidCharge  = 4'd8
    } opcode_t;

    typedef logic [1:0] err_t;
    localparam err_t ErrOk = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        RESP,
        ROUND,
        ERRHALT
    } seq_state_t;

    typedef struct packed {
        logic        round;
        logic [3:0]  op;
        logic [31:0] data;
    } cmd_t;

    localparam int unsigned CmdWidth = $bits(cmd_t);

    // A zero-length round still holds C_start for one cycle.
    function automatic logic [15:0] round_len(input logic [15:0] dur);
        return (dur == 16'd0) ? 16'd1 : dur;
    endfunction

endpackage

// File: rtl/bid_cmd_fifo.sv
// Synchronous FIFO with wrap-bit pointers; read data is the current head entry.
module bid_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bid_cmd_sequencer.sv
// Host command front end for bids22: buffers commands, strobes opcodes, runs timed rounds,
// and tracks error responses.
module bid_cmd_sequencer
    import bids22_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter bit          HALT_ON_ERR = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_round,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_data,
    input  logic        clear_err,
    output logic [3:0]  C_op,
    output logic [31:0] C_data,
    output logic        C_start,
    input  logic [1:0]  err,
    input  logic        roundOver,
    output logic        busy,
    output logic [1:0]  status_err,
    output logic [7:0]  err_count,
    output logic [15:0] cmd_count
);

    cmd_t       push_cmd;
    cmd_t       head_cmd;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;

    seq_state_t  state_q, state_d;
    logic [3:0]  hold_op_q, hold_op_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  c_op_q, c_op_d;
    logic [31:0] c_data_q, c_data_d;
    logic        c_start_q, c_start_d;
    err_t        status_q, status_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [15:0] cmd_cnt_q, cmd_cnt_d;

    assign push_cmd = {cmd_round, cmd_op, cmd_data};

    bid_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CmdWidth)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cmd_valid),
        .wdata   (push_cmd),
        .pop     (pop),
        .rdata   (head_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        hold_op_d   = hold_op_q;
        hold_data_d = hold_data_q;
        cnt_d       = cnt_q;
        c_op_d      = NoOp;
        c_data_d    = '0;
        c_start_d   = 1'b0;
        status_d    = status_q;
        err_cnt_d   = err_cnt_q;
        cmd_cnt_d   = cmd_cnt_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    hold_op_d   = head_cmd.op;
                    hold_data_d = head_cmd.data;
                    if (head_cmd.round) begin
                        // C_start is registered, so it rises on the same edge as the pop.
                        c_start_d = 1'b1;
                        cnt_d     = round_len(head_cmd.data[15:0]);
                        state_d   = ROUND;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                c_op_d   = hold_op_q;
                c_data_d = hold_data_q;
                state_d  = RESP;
            end
            RESP: begin
                cmd_cnt_d = cmd_cnt_q + 16'd1;
                if (err != ErrOk) begin
                    status_d = err;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    state_d = HALT_ON_ERR ? ERRHALT : IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            ROUND: begin
                if (roundOver || (cnt_q == 16'd1)) begin
                    cmd_cnt_d = cmd_cnt_q + 16'd1;
                    state_d   = IDLE;
                end else begin
                    c_start_d = 1'b1;
                    cnt_d     = cnt_q - 16'd1;
                end
            end
            ERRHALT: begin
                if (clear_err) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            hold_op_q   <= '0;
            hold_data_q <= '0;
            cnt_q       <= '0;
            c_op_q      <= NoOp;
            c_data_q    <= '0;
            c_start_q   <= 1'b0;
            status_q    <= ErrOk;
            err_cnt_q   <= '0;
            cmd_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_op_q   <= hold_op_d;
            hold_data_q <= hold_data_d;
            cnt_q       <= cnt_d;
            c_op_q      <= c_op_d;
            c_data_q    <= c_data_d;
            c_start_q   <= c_start_d;
            status_q    <= status_d;
            err_cnt_q   <= err_cnt_d;
            cmd_cnt_q   <= cmd_cnt_d;
        end
    end

    assign cmd_ready  = !fifo_full;
    assign C_op       = c_op_q;
    assign C_data     = c_data_q;
    assign C_start    = c_start_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign status_err = status_q;
    assign err_count  = err_cnt_q;
    assign cmd_count  = cmd_cnt_q;

endmodule

// File: tb/tb_bid_cmd_sequencer.sv
// Bench for bid_cmd_sequencer: timeline model for random traffic plus directed error,
// round-abort, async-reset and error-saturation scenarios.
module tb_bid_cmd_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int TL   = 1024;
    localparam int MAXC = 128;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_round;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        clear_err;
    logic [1:0]  err;
    logic        roundOver;

    logic        h_cmd_ready, h_C_start, h_busy;
    logic [3:0]  h_C_op;
    logic [31:0] h_C_data;
    logic [1:0]  h_status_err;
    logic [7:0]  h_err_count;
    logic [15:0] h_cmd_count;

    logic        n_cmd_ready, n_C_start, n_busy;
    logic [3:0]  n_C_op;
    logic [31:0] n_C_data;
    logic [1:0]  n_status_err;
    logic [7:0]  n_err_count;
    logic [15:0] n_cmd_count;

    bid_cmd_sequencer #(.DEPTH(DEPTH), .HALT_ON_ERR(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(h_cmd_ready),
        .cmd_round(cmd_round), .cmd_op(cmd_op), .cmd_data(cmd_data), .clear_err(clear_err),
        .C_op(h_C_op), .C_data(h_C_data), .C_start(h_C_start), .err(err),
        .roundOver(roundOver), .busy(h_busy), .status_err(h_status_err),
        .err_count(h_err_count), .cmd_count(h_cmd_count)
    );

    bid_cmd_sequencer #(.DEPTH(DEPTH), .HALT_ON_ERR(1'b0)) dut_nh (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(n_cmd_ready),
        .cmd_round(cmd_round), .cmd_op(cmd_op), .cmd_data(cmd_data), .clear_err(clear_err),
        .C_op(n_C_op), .C_data(n_C_data), .C_start(n_C_start), .err(err),
        .roundOver(roundOver), .busy(n_busy), .status_err(n_status_err),
        .err_count(n_err_count), .cmd_count(n_cmd_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Expected per-cycle bids22 drive, built from each command's schedule.
    logic [3:0]  exp_op    [TL];
    logic [31:0] exp_data  [TL];
    bit          exp_start [TL];
    int push_e [MAXC];
    int pop_e  [MAXC];
    int done_e [MAXC];
    int n_cmds;
    int free_e;

    bit          pend;
    bit          pend_round;
    logic [3:0]  pend_op;
    logic [31:0] pend_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int occ_at(input int c);
        int n = 0;
        for (int i = 0; i < n_cmds; i++) if (push_e[i] <= c && pop_e[i] > c) n++;
        return n;
    endfunction

    function automatic int live_at(input int c);
        int n = 0;
        for (int i = 0; i < n_cmds; i++) if (push_e[i] <= c && done_e[i] > c) n++;
        return n;
    endfunction

    function automatic int done_at(input int c);
        int n = 0;
        for (int i = 0; i < n_cmds; i++) if (done_e[i] <= c) n++;
        return n;
    endfunction

    task automatic model_reset();
        n_cmds = 0;
        free_e = 0;
        pend   = 1'b0;
        for (int i = 0; i < TL; i++) begin
            exp_op[i]    = 4'd0;
            exp_data[i]  = 32'd0;
            exp_start[i] = 1'b0;
        end
    endtask

    // A command pushed at edge n is popped at the later of n+1 and the first idle pop edge.
    task automatic schedule(input int n);
        int p;
        int d;
        if (n_cmds >= MAXC) return;
        p = (n + 1 > free_e) ? n + 1 : free_e;
        push_e[n_cmds] = n;
        pop_e[n_cmds]  = p;
        if (pend_round) begin
            d = (pend_data[15:0] == 16'd0) ? 1 : int'(pend_data[15:0]);
            for (int k = 0; k < d; k++) if (p + k < TL) exp_start[p + k] = 1'b1;
            done_e[n_cmds] = p + d;
            free_e = p + d + 1;
        end else begin
            if (p + 1 < TL) begin
                exp_op[p + 1]   = pend_op;
                exp_data[p + 1] = pend_data;
            end
            done_e[n_cmds] = p + 2;
            free_e = p + 3;
        end
        n_cmds++;
    endtask

    task automatic check_tl();
        int c = cyc;
        if (c >= TL) return;
        chk("c_op", 32'(h_C_op), 32'(exp_op[c]));
        chk("c_data", h_C_data, exp_data[c]);
        chk("c_start", 32'(h_C_start), 32'(exp_start[c]));
        chk("cmd_ready", 32'(h_cmd_ready), 32'(occ_at(c) < int'(DEPTH)));
        chk("busy", 32'(h_busy), 32'(live_at(c) > 0));
        chk("cmd_count", 32'(h_cmd_count), 32'(done_at(c)));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (pend) begin
            schedule(cyc);
            pend = 1'b0;
        end
        @(negedge clk);
        if (chk_en) check_tl();
    endtask

    task automatic push(input bit rnd, input logic [3:0] op, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_round = rnd;
        cmd_op    = op;
        cmd_data  = data;
        if (chk_en && occ_at(cyc) < int'(DEPTH)) begin
            pend       = 1'b1;
            pend_round = rnd;
            pend_op    = op;
            pend_data  = data;
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] ops [5];
        int base;
        int e_cyc;
        int pushed;
        bit accept;
        logic [3:0] want;

        ops[0] = 4'd1; ops[1] = 4'd2; ops[2] = 4'd4; ops[3] = 4'd5; ops[4] = 4'd6;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_round = 1'b0; cmd_op = 4'd0;
        cmd_data = 32'd0; clear_err = 1'b0; err = 2'b00; roundOver = 1'b0;
        model_reset();

        // Reset values
        tick(); tick();
        reset_n = 1'b1;
        chk("rst_ready", 32'(h_cmd_ready), 32'd1);
        chk("rst_busy", 32'(h_busy), 32'd0);
        chk("rst_c_op", 32'(h_C_op), 32'd0);
        chk("rst_c_data", h_C_data, 32'd0);
        chk("rst_c_start", 32'(h_C_start), 32'd0);
        chk("rst_status", 32'(h_status_err), 32'd0);
        chk("rst_errcnt", 32'(h_err_count), 32'd0);
        chk("rst_cmdcnt", 32'(h_cmd_count), 32'd0);

        // Directed traffic under the timeline model
        chk_en = 1'b1;
        push(1'b0, 4'd1, 32'h0F0F0F0F);
        repeat (4) tick();
        push(1'b1, 4'd0, 32'd5);
        repeat (8) tick();
        push(1'b1, 4'd9, 32'hABCD0000);
        repeat (3) tick();

        // Random traffic with back-pressure
        for (int i = 0; i < 70; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                if ($urandom_range(0, 9) < 3)
                    push(1'b1, 4'($urandom_range(0, 15)), {16'($urandom), 16'($urandom_range(0, 6))});
                else
                    push(1'b0, 4'($urandom_range(1, 15)), $urandom);
            end else begin
                tick();
            end
        end
        repeat (80) tick();
        chk_en = 1'b0;
        base = n_cmds;

        // roundOver in the 3rd high cycle cuts a 5-cycle round
        push(1'b1, 4'd0, 32'd5);
        tick(); chk("ro_hi1", 32'(h_C_start), 32'd1);
        tick(); chk("ro_hi2", 32'(h_C_start), 32'd1);
        tick(); chk("ro_hi3", 32'(h_C_start), 32'd1);
        roundOver = 1'b1;
        tick(); chk("ro_lo4", 32'(h_C_start), 32'd0);
        roundOver = 1'b0;
        chk("ro_cmdcnt", 32'(h_cmd_count), 32'(base + 1));
        tick(); chk("ro_lo5", 32'(h_C_start), 32'd0);
        chk("ro_busy", 32'(h_busy), 32'd0);

        // Asynchronous reset in the middle of a round
        push(1'b1, 4'd0, 32'd20);
        tick(); tick();
        chk("rr_hi", 32'(h_C_start), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("rr_async_start", 32'(h_C_start), 32'd0);
        chk("rr_async_cnt", 32'(h_cmd_count), 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        chk("rr_ready", 32'(h_cmd_ready), 32'd1);
        chk("rr_busy", 32'(h_busy), 32'd0);
        chk("rr_errcnt", 32'(h_err_count), 32'd0);

        // Error halt, back-pressure while halted, then ordered drain after clear_err
        push(1'b0, 4'd3, 32'h00001234);
        tick(); chk("ex_pre", 32'(h_C_op), 32'd0);
        tick(); chk("ex_strobe", 32'(h_C_op), 32'd3);
        err = 2'b01;
        tick();
        err = 2'b00;
        chk("ex_status", 32'(h_status_err), 32'd1);
        chk("ex_errcnt", 32'(h_err_count), 32'd1);
        chk("ex_cmdcnt", 32'(h_cmd_count), 32'd1);
        chk("ex_busy", 32'(h_busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 32'(h_cmd_ready), 32'(i < 4));
            push(1'b0, ops[i], 32'(100 + i));
            chk("halt_noop", 32'(h_C_op), 32'd0);
        end
        chk("bp_full", 32'(h_cmd_ready), 32'd0);
        repeat (3) begin
            tick();
            chk("halt_wait", 32'(h_C_op), 32'd0);
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        e_cyc = cyc;
        for (int t = 1; t <= 12; t++) begin
            tick();
            want = 4'd0;
            if (t >= 2 && (t - 2) % 3 == 0 && (t - 2) / 3 < 4) want = ops[(t - 2) / 3];
            chk("drain_op", 32'(h_C_op), 32'(want));
            if (want != 4'd0) chk("drain_data", h_C_data, 32'(100 + (t - 2) / 3));
        end
        chk("drain_cyc", 32'(cyc - e_cyc), 32'd12);
        chk("drain_cmdcnt", 32'(h_cmd_count), 32'd5);
        chk("drain_status", 32'(h_status_err), 32'd1);
        chk("drain_errcnt", 32'(h_err_count), 32'd1);
        chk("drain_busy", 32'(h_busy), 32'd0);

        // 300 erroring commands: non-halting instance saturates err_count
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        err = 2'b10;
        pushed = 0;
        for (int t = 0; t < 1500; t++) begin
            if (pushed == 300 && n_cmd_count == 16'd300) break;
            cmd_valid = (pushed < 300);
            cmd_round = 1'b0;
            cmd_op    = 4'd4;
            cmd_data  = 32'(t);
            accept    = cmd_valid && n_cmd_ready;
            tick();
            if (accept) pushed++;
        end
        cmd_valid = 1'b0;
        err = 2'b00;
        chk("sat_pushed", 32'(pushed), 32'd300);
        chk("sat_cmdcnt", 32'(n_cmd_count), 32'd300);
        chk("sat_errcnt", 32'(n_err_count), 32'd255);
        chk("sat_status", 32'(n_status_err), 32'd2);
        chk("sat_busy", 32'(n_busy), 32'd0);
        chk("halt_only_one", 32'(h_cmd_count), 32'd1);
        chk("halt_errcnt", 32'(h_err_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
